// File: rtl/hw_accel_pixel_packer_pkg.sv
// Shared constants and helpers for the pixel packer.
// Default geometry plus derivation functions for other parameter sets.
package hw_accel_pixel_packer_pkg;

  localparam int DEF_PIXEL_DATA_WIDTH = 8;
  localparam int DEF_PPC              = 1;
  localparam int DEF_OUT_DATA_WIDTH   = 32;
  localparam int DEF_FRAME_WIDTH      = 3;
  localparam int DEF_FRAME_HEIGHT     = 3;

  localparam int PIX_PER_WORD =
    DEF_OUT_DATA_WIDTH / DEF_PIXEL_DATA_WIDTH;
  localparam int BEATS_PER_WORD = PIX_PER_WORD / DEF_PPC;
  localparam int FRAME_BEATS =
    DEF_FRAME_WIDTH * DEF_FRAME_HEIGHT / DEF_PPC;
  localparam int KEEP_WIDTH = DEF_OUT_DATA_WIDTH / 8;

  localparam int KEEP_MAX = 64;

  function automatic int beats_per_word(
    input int out_w,
    input int pix_w,
    input int ppc
  );
    return (out_w / pix_w) / ppc;
  endfunction

  function automatic int frame_beats(
    input int fw,
    input int fh,
    input int ppc
  );
    return (fw * fh) / ppc;
  endfunction

  function automatic logic [KEEP_MAX-1:0] keep_mask(
    input int filled_pixels,
    input int pix_w
  );
    logic [KEEP_MAX-1:0] m;
    int nbytes;
    nbytes = (filled_pixels * pix_w) / 8;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (i < nbytes) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hw_accel_pixel_packer_if.sv
// Ready/valid word stream from the packer toward the DMA writer.
// Master drives data/keep/last/valid, slave drives ready.
interface hw_accel_pixel_packer_if #(
  parameter int DATA_WIDTH = 32
);

  localparam int KW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] out_tdata;
  logic [KW-1:0]         out_tkeep;
  logic                  out_tlast;
  logic                  out_tvalid;
  logic                  out_tready;

  modport master (
    output out_tdata,
    output out_tkeep,
    output out_tlast,
    output out_tvalid,
    input  out_tready
  );

  modport slave (
    input  out_tdata,
    input  out_tkeep,
    input  out_tlast,
    input  out_tvalid,
    output out_tready
  );

endinterface

// File: rtl/hw_accel_sync_fifo.sv
// First-word fall-through synchronous FIFO.
// A write while full is accepted only when a read happens in the same cycle.
module hw_accel_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok & ~rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok & ~wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/hw_accel_pixel_packer.sv
// Packs the downscaled pixel stream into bus words with frame tlast,
// buffering through a small FIFO and flagging words dropped when it is full.
module hw_accel_pixel_packer
  import hw_accel_pixel_packer_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int PPC              = 1,
  parameter int OUT_DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH      = 3,
  parameter int FRAME_HEIGHT     = 3,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PPC*PIXEL_DATA_WIDTH-1:0] in_pixel_data,
  input  logic                            in_pixel_data_valid,
  hw_accel_pixel_packer_if.master         axis,
  output logic                            frame_done,
  output logic                            overflow
);

  localparam int BW  = PPC * PIXEL_DATA_WIDTH;
  localparam int BPW =
    beats_per_word(OUT_DATA_WIDTH, PIXEL_DATA_WIDTH, PPC);
  localparam int FB  = frame_beats(FRAME_WIDTH, FRAME_HEIGHT, PPC);
  localparam int KW  = OUT_DATA_WIDTH / 8;
  localparam int EW  = OUT_DATA_WIDTH + KW + 1;

  logic [15:0]               beat_idx;
  logic [15:0]               frame_beat;
  logic [OUT_DATA_WIDTH-1:0] asm_q;
  logic [OUT_DATA_WIDTH-1:0] asm_nxt;
  logic [KW-1:0]             keep_nxt;
  logic                      word_end;
  logic                      frame_end;
  logic                      close;

  logic                      push_vld;
  logic                      push_last;
  logic [OUT_DATA_WIDTH-1:0] push_data;
  logic [KW-1:0]             push_keep;

  logic                      full;
  logic                      empty;
  logic                      pop;
  logic                      wr_en;
  logic [EW-1:0]             rd_data;

  assign frame_end = frame_beat == 16'(FB - 1);
  assign word_end  = beat_idx == 16'(BPW - 1);
  assign close     = in_pixel_data_valid & (word_end | frame_end);

  always_comb begin
    asm_nxt = asm_q;
    for (int s = 0; s < BPW; s++) begin
      if (beat_idx == 16'(s)) asm_nxt[s*BW +: BW] = in_pixel_data;
    end
  end

  // Filled pixels includes the closing beat; a full word yields all ones.
  assign keep_nxt = KW'(keep_mask(
    (int'(beat_idx) + 1) * PPC, PIXEL_DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx   <= '0;
      frame_beat <= '0;
      asm_q      <= '0;
      push_vld   <= 1'b0;
      push_last  <= 1'b0;
      push_data  <= '0;
      push_keep  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      push_vld   <= close;
      frame_done <= in_pixel_data_valid & frame_end;
      if (in_pixel_data_valid) begin
        if (close) begin
          beat_idx  <= '0;
          asm_q     <= '0;
          push_data <= asm_nxt;
          push_keep <= keep_nxt;
          push_last <= frame_end;
        end else begin
          beat_idx <= beat_idx + 16'd1;
          asm_q    <= asm_nxt;
        end
        frame_beat <= frame_end ? '0 : frame_beat + 16'd1;
      end
      if (push_vld & full & ~pop) overflow <= 1'b1;
    end
  end

  assign pop   = ~empty & axis.out_tready;
  assign wr_en = push_vld & (~full | pop);

  hw_accel_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({push_last, push_keep, push_data}),
    .full    (full),
    .rd_en   (pop),
    .rd_data (rd_data),
    .empty   (empty)
  );

  assign axis.out_tvalid = ~empty;
  assign axis.out_tdata  =
    empty ? '0 : rd_data[OUT_DATA_WIDTH-1:0];
  assign axis.out_tkeep  =
    empty ? '0 : rd_data[OUT_DATA_WIDTH +: KW];
  assign axis.out_tlast  = ~empty & rd_data[EW-1];

endmodule

// File: tb/tb_hw_accel_pixel_packer.sv
// Directed bench for the pixel packer across three parameter sets:
// default, shallow FIFO with 8x4 frame, and two pixels per beat.
module tb_hw_accel_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  a_pix;
  logic        a_vld;
  logic        a_fd;
  logic        a_ovf;
  logic [7:0]  b_pix;
  logic        b_vld;
  logic        b_fd;
  logic        b_ovf;
  logic [15:0] c_pix;
  logic        c_vld;
  logic        c_fd;
  logic        c_ovf;

  hw_accel_pixel_packer_if #(.DATA_WIDTH(32)) a_axis ();
  hw_accel_pixel_packer_if #(.DATA_WIDTH(32)) b_axis ();
  hw_accel_pixel_packer_if #(.DATA_WIDTH(32)) c_axis ();

  hw_accel_pixel_packer u_a (
    .clk                 (clk),
    .rst                 (rst),
    .in_pixel_data       (a_pix),
    .in_pixel_data_valid (a_vld),
    .axis                (a_axis),
    .frame_done          (a_fd),
    .overflow            (a_ovf)
  );

  hw_accel_pixel_packer #(
    .FRAME_WIDTH  (8),
    .FRAME_HEIGHT (4),
    .FIFO_DEPTH   (2)
  ) u_b (
    .clk                 (clk),
    .rst                 (rst),
    .in_pixel_data       (b_pix),
    .in_pixel_data_valid (b_vld),
    .axis                (b_axis),
    .frame_done          (b_fd),
    .overflow            (b_ovf)
  );

  hw_accel_pixel_packer #(
    .PPC          (2),
    .FRAME_WIDTH  (4),
    .FRAME_HEIGHT (3)
  ) u_c (
    .clk                 (clk),
    .rst                 (rst),
    .in_pixel_data       (c_pix),
    .in_pixel_data_valid (c_vld),
    .axis                (c_axis),
    .frame_done          (c_fd),
    .overflow            (c_ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Accepted words as {last, keep[3:0], data[31:0]}.
  logic [36:0] qa [$];
  logic [36:0] qb [$];
  logic [36:0] qc [$];
  int fd_a = 0;
  int fd_cyc_a = -1;
  int first_a = -1;

  logic        sa_v, sa_r, pa_v, pa_r;
  logic [36:0] sa_w, pa_w;

  // Sample everything at negedge, then move to just after posedge to drive.
  task automatic tick();
    @(negedge clk);
    pa_v = sa_v;
    pa_r = sa_r;
    pa_w = sa_w;
    sa_v = a_axis.out_tvalid;
    sa_r = a_axis.out_tready;
    sa_w = {a_axis.out_tlast, a_axis.out_tkeep, a_axis.out_tdata};
    if (!rst) begin
      if (sa_v && sa_r) qa.push_back(sa_w);
      if (a_fd) begin
        fd_a++;
        fd_cyc_a = cyc;
      end
      if (sa_v && first_a < 0) first_a = cyc;
      if (b_axis.out_tvalid && b_axis.out_tready)
        qb.push_back({b_axis.out_tlast, b_axis.out_tkeep,
                      b_axis.out_tdata});
      if (c_axis.out_tvalid && c_axis.out_tready)
        qc.push_back({c_axis.out_tlast, c_axis.out_tkeep,
                      c_axis.out_tdata});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    a_pix = '0; b_pix = '0; c_pix = '0;
    a_axis.out_tready = 1'b0;
    b_axis.out_tready = 1'b0;
    c_axis.out_tready = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_axis.out_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid got %b exp 0", a_axis.out_tvalid);
    end
    checks++;
    if (a_axis.out_tdata !== 32'h0) begin
      errors++; $display("FAIL reset_tdata got %h exp 0", a_axis.out_tdata);
    end
    checks++;
    if (a_axis.out_tkeep !== 4'h0) begin
      errors++; $display("FAIL reset_tkeep got %h exp 0", a_axis.out_tkeep);
    end
    checks++;
    if (a_axis.out_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_tlast got %b exp 0", a_axis.out_tlast);
    end
    checks++;
    if (a_fd !== 1'b0 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fd=%b ovf=%b exp 0", a_fd, a_ovf);
    end
    checks++;
    if (b_axis.out_tvalid !== 1'b0 || c_axis.out_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_bc_tvalid got %b %b exp 0",
        b_axis.out_tvalid, c_axis.out_tvalid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    logic [36:0] exp_w [3];
    int c3, c8;
    exp_w[0] = {1'b0, 4'hF, 32'h04030201};
    exp_w[1] = {1'b0, 4'hF, 32'h08070605};
    exp_w[2] = {1'b1, 4'h1, 32'h00000009};
    qa.delete();
    fd_a = 0;
    first_a = -1;
    c3 = 0; c8 = 0;
    a_axis.out_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) c3 = cyc;
      if (i == 8) c8 = cyc;
      a_pix = 8'(i + 1);
      a_vld = 1'b1;
      tick();
    end
    a_vld = 1'b0;
    repeat (6) tick();
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL single_count got %0d exp 3", qa.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < qa.size()) begin
        checks++;
        if (qa[i] !== exp_w[i]) begin
          errors++; $display("FAIL single_word%0d got %h exp %h", i, qa[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (first_a != c3 + 2) begin
      errors++; $display("FAIL single_latency got %0d exp %0d", first_a, c3 + 2);
    end
    checks++;
    if (fd_a != 1) begin
      errors++; $display("FAIL single_frame_done_count got %0d exp 1", fd_a);
    end
    checks++;
    if (fd_cyc_a != c8 + 1) begin
      errors++; $display("FAIL single_frame_done_cycle got %0d exp %0d",
        fd_cyc_a, c8 + 1);
    end
    checks++;
    if (a_ovf !== 1'b0) begin
      errors++; $display("FAIL single_overflow got %b exp 0", a_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp_w [6];
    exp_w[0] = {1'b0, 4'hF, 32'h0D0C0B0A};
    exp_w[1] = {1'b0, 4'hF, 32'h11100F0E};
    exp_w[2] = {1'b1, 4'h1, 32'h00000012};
    exp_w[3] = {1'b0, 4'hF, 32'h16151413};
    exp_w[4] = {1'b0, 4'hF, 32'h1A191817};
    exp_w[5] = {1'b1, 4'h1, 32'h0000001B};
    qa.delete();
    fd_a = 0;
    a_axis.out_tready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a_pix = 8'(8'h0A + i);
      a_vld = 1'b1;
      tick();
    end
    a_vld = 1'b0;
    repeat (6) tick();
    checks++;
    if (qa.size() != 6) begin
      errors++; $display("FAIL b2b_count got %0d exp 6", qa.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < qa.size()) begin
        checks++;
        if (qa[i] !== exp_w[i]) begin
          errors++; $display("FAIL b2b_word%0d got %h exp %h", i, qa[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (fd_a != 2) begin
      errors++; $display("FAIL b2b_frame_done_count got %0d exp 2", fd_a);
    end
  endtask

  task automatic test_stall();
    logic [36:0] exp_w [3];
    int stalls;
    exp_w[0] = {1'b0, 4'hF, 32'h24232221};
    exp_w[1] = {1'b0, 4'hF, 32'h28272625};
    exp_w[2] = {1'b1, 4'h1, 32'h00000029};
    qa.delete();
    stalls = 0;
    for (int i = 0; i < 30; i++) begin
      a_axis.out_tready = (i % 2) == 0;
      if (i < 9) begin
        a_pix = 8'(8'h21 + i);
        a_vld = 1'b1;
      end else begin
        a_vld = 1'b0;
      end
      tick();
      if (pa_v && !pa_r) begin
        stalls++;
        checks++;
        if (!sa_v || sa_w !== pa_w) begin
          errors++; $display("FAIL stall_hold got v=%b %h exp v=1 %h",
            sa_v, sa_w, pa_w);
        end
      end
    end
    a_axis.out_tready = 1'b1;
    repeat (4) tick();
    checks++;
    if (stalls == 0) begin
      errors++; $display("FAIL stall_seen got 0 stalled cycles exp >0");
    end
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL stall_count got %0d exp 3", qa.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < qa.size()) begin
        checks++;
        if (qa[i] !== exp_w[i]) begin
          errors++; $display("FAIL stall_word%0d got %h exp %h", i, qa[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [36:0] exp_w [3];
    exp_w[0] = {1'b0, 4'hF, 32'h34333231};
    exp_w[1] = {1'b0, 4'hF, 32'h38373635};
    exp_w[2] = {1'b1, 4'h1, 32'h00000039};
    a_axis.out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_pix = 8'(8'h41 + i);
      a_vld = 1'b1;
      tick();
    end
    a_vld = 1'b0;
    repeat (2) tick();
    checks++;
    if (a_axis.out_tvalid !== 1'b1) begin
      errors++; $display("FAIL midrst_queued got %b exp 1", a_axis.out_tvalid);
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (a_axis.out_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_flushed got %b exp 0", a_axis.out_tvalid);
    end
    qa.delete();
    a_axis.out_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_pix = 8'(8'h31 + i);
      a_vld = 1'b1;
      tick();
    end
    a_vld = 1'b0;
    repeat (6) tick();
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL midrst_count got %0d exp 3", qa.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < qa.size()) begin
        checks++;
        if (qa[i] !== exp_w[i]) begin
          errors++; $display("FAIL midrst_word%0d got %h exp %h", i, qa[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (a_ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_overflow got %b exp 0", a_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [36:0] e;
    logic [7:0]  p;
    b_axis.out_tready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b_pix = 8'(i + 1);
      b_vld = 1'b1;
      tick();
    end
    b_vld = 1'b0;
    repeat (4) tick();
    checks++;
    if (b_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b exp 1", b_ovf);
    end
    checks++;
    if (b_axis.out_tvalid !== 1'b1 || b_axis.out_tdata !== 32'h04030201) begin
      errors++; $display("FAIL ovf_head got v=%b %h exp v=1 04030201",
        b_axis.out_tvalid, b_axis.out_tdata);
    end
    qb.delete();
    b_axis.out_tready = 1'b1;
    repeat (8) tick();
    checks++;
    if (qb.size() != 2) begin
      errors++; $display("FAIL ovf_drain_count got %0d exp 2", qb.size());
    end
    if (qb.size() == 2) begin
      checks++;
      if (qb[0] !== {1'b0, 4'hF, 32'h04030201}
          || qb[1] !== {1'b0, 4'hF, 32'h08070605}) begin
        errors++; $display("FAIL ovf_drain_words got %h %h exp 0f04030201 0f08070605",
          qb[0], qb[1]);
      end
    end
    qb.delete();
    for (int i = 0; i < 32; i++) begin
      b_pix = 8'(8'h41 + i);
      b_vld = 1'b1;
      tick();
    end
    b_vld = 1'b0;
    repeat (6) tick();
    checks++;
    if (qb.size() != 8) begin
      errors++; $display("FAIL ovf_next_count got %0d exp 8", qb.size());
    end
    for (int j = 0; j < 8; j++) begin
      if (j < qb.size()) begin
        p = 8'(8'h41 + 4 * j);
        e = {(j == 7), 4'hF, p + 8'd3, p + 8'd2, p + 8'd1, p};
        checks++;
        if (qb[j] !== e) begin
          errors++; $display("FAIL ovf_next_word%0d got %h exp %h", j, qb[j], e);
        end
      end
    end
    checks++;
    if (b_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b exp 1", b_ovf);
    end
  endtask

  task automatic test_ppc2();
    logic [36:0] exp_w [3];
    logic [7:0]  lo;
    exp_w[0] = {1'b0, 4'hF, 32'h04030201};
    exp_w[1] = {1'b0, 4'hF, 32'h08070605};
    exp_w[2] = {1'b1, 4'hF, 32'h0C0B0A09};
    qc.delete();
    c_axis.out_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lo = 8'(2 * i + 1);
      c_pix = {lo + 8'd1, lo};
      c_vld = 1'b1;
      tick();
    end
    c_vld = 1'b0;
    repeat (6) tick();
    checks++;
    if (qc.size() != 3) begin
      errors++; $display("FAIL ppc2_count got %0d exp 3", qc.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < qc.size()) begin
        checks++;
        if (qc[i] !== exp_w[i]) begin
          errors++; $display("FAIL ppc2_word%0d got %h exp %h", i, qc[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (c_ovf !== 1'b0) begin
      errors++; $display("FAIL ppc2_overflow got %b exp 0", c_ovf);
    end
  endtask

  initial begin
    sa_v = 1'b0; sa_r = 1'b0; sa_w = '0;
    pa_v = 1'b0; pa_r = 1'b0; pa_w = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_overflow();
    test_ppc2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
